// File: rtl/xor_accum_pipe.sv
// Per-beat XOR/XNOR with a running packet checksum, buffered in a DEPTH-entry output FIFO.
// Optional per-entry parity output (out_par) when XOR_ACCUM_PARITY_EN is defined.
module xor_accum_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_inv,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [W-1:0]  out_acc,
    output logic          out_last,
    output logic [CW-1:0] pkt_cnt
`ifdef XOR_ACCUM_PARITY_EN
    ,
    output logic          out_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [W-1:0]     data_mem_q [DEPTH];
    logic [W-1:0]     data_mem_d [DEPTH];
    logic [W-1:0]     accm_mem_q [DEPTH];
    logic [W-1:0]     accm_mem_d [DEPTH];
    logic [DEPTH-1:0] last_mem_q, last_mem_d;

    // Holds the last delivered head so the output ports stay stable while empty.
    logic [W-1:0] hold_data_q, hold_data_d;
    logic [W-1:0] hold_acc_q, hold_acc_d;
    logic         hold_last_q, hold_last_d;

`ifdef XOR_ACCUM_PARITY_EN
    logic [DEPTH-1:0] par_mem_q, par_mem_d;
    logic             hold_par_q, hold_par_d;
`endif

    logic         push;
    logic         pop;
    logic [W-1:0] r;
    logic [W-1:0] acc_next;

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign r         = in_inv ? ~(in_a ^ in_b) : (in_a ^ in_b);
    assign acc_next  = acc_q ^ r;

    assign out_data = out_valid ? data_mem_q[rd_ptr_q] : hold_data_q;
    assign out_acc  = out_valid ? accm_mem_q[rd_ptr_q] : hold_acc_q;
    assign out_last = out_valid ? last_mem_q[rd_ptr_q] : hold_last_q;
    assign pkt_cnt  = pkt_cnt_q;
`ifdef XOR_ACCUM_PARITY_EN
    assign out_par  = out_valid ? par_mem_q[rd_ptr_q] : hold_par_q;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        pkt_cnt_d   = pkt_cnt_q;
        data_mem_d  = data_mem_q;
        accm_mem_d  = accm_mem_q;
        last_mem_d  = last_mem_q;
        hold_data_d = out_data;
        hold_acc_d  = out_acc;
        hold_last_d = out_last;
`ifdef XOR_ACCUM_PARITY_EN
        par_mem_d   = par_mem_q;
        hold_par_d  = out_par;
`endif

        if (push) begin
            data_mem_d[wr_ptr_q] = r;
            accm_mem_d[wr_ptr_q] = acc_next;
            last_mem_d[wr_ptr_q] = in_last;
`ifdef XOR_ACCUM_PARITY_EN
            par_mem_d[wr_ptr_q]  = ^r;
`endif
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (in_last) begin
                acc_d     = '0;
                pkt_cnt_d = pkt_cnt_q + CW'(1);
            end else begin
                acc_d = acc_next;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            pkt_cnt_q   <= '0;
            data_mem_q  <= '{default: '0};
            accm_mem_q  <= '{default: '0};
            last_mem_q  <= '0;
            hold_data_q <= '0;
            hold_acc_q  <= '0;
            hold_last_q <= 1'b0;
`ifdef XOR_ACCUM_PARITY_EN
            par_mem_q   <= '0;
            hold_par_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            pkt_cnt_q   <= pkt_cnt_d;
            data_mem_q  <= data_mem_d;
            accm_mem_q  <= accm_mem_d;
            last_mem_q  <= last_mem_d;
            hold_data_q <= hold_data_d;
            hold_acc_q  <= hold_acc_d;
            hold_last_q <= hold_last_d;
`ifdef XOR_ACCUM_PARITY_EN
            par_mem_q   <= par_mem_d;
            hold_par_q  <= hold_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_xor_accum_pipe.sv
// Directed self-checking bench for xor_accum_pipe (W=8, DEPTH=2, CW=16).
// Parity checks are compiled in only when XOR_ACCUM_PARITY_EN is defined.
module tb_xor_accum_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_inv;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [7:0]  out_acc;
    logic        out_last;
    logic [15:0] pkt_cnt;
`ifdef XOR_ACCUM_PARITY_EN
    logic        out_par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xor_accum_pipe #(.W(8), .DEPTH(2), .CW(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_inv    (in_inv),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_acc   (out_acc),
        .out_last  (out_last),
        .pkt_cnt   (pkt_cnt)
`ifdef XOR_ACCUM_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic inv, input logic last);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_inv   = inv;
        in_last  = last;
    endtask

    logic [7:0] r_m;
    logic [7:0] acc_m;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_acc",   32'(out_acc),   32'h0);
        chk("rst_out_last",  32'(out_last),  32'h0);
        chk("rst_pkt_cnt",   32'(pkt_cnt),   32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'h1);

        // single-beat packet
        out_ready = 1'b1;
        drive(1'b1, 8'hFF, 8'h0F, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data",  32'(out_data),  32'hF0);
        chk("single_acc",   32'(out_acc),   32'hF0);
        chk("single_last",  32'(out_last),  32'h1);
        chk("single_pkt",   32'(pkt_cnt),   32'h1);
        tick();
        chk("drain_valid",  32'(out_valid), 32'h0);
        chk("drain_hold",   32'(out_data),  32'hF0);

        // three-beat packet streamed, then a single-beat packet
        drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        tick();
        chk("p3_b1_data", 32'(out_data), 32'h01);
        chk("p3_b1_acc",  32'(out_acc),  32'h01);
        chk("p3_b1_last", 32'(out_last), 32'h0);
        drive(1'b1, 8'h02, 8'h00, 1'b0, 1'b0);
        tick();
        chk("p3_b2_data", 32'(out_data), 32'h02);
        chk("p3_b2_acc",  32'(out_acc),  32'h03);
        drive(1'b1, 8'h04, 8'h00, 1'b0, 1'b1);
        tick();
        chk("p3_b3_data", 32'(out_data), 32'h04);
        chk("p3_b3_acc",  32'(out_acc),  32'h07);
        chk("p3_b3_last", 32'(out_last), 32'h1);
        chk("p3_pkt",     32'(pkt_cnt),  32'h2);
        drive(1'b1, 8'h10, 8'h01, 1'b0, 1'b1);
        tick();
        chk("p4_acc",     32'(out_acc),  32'h11);
        chk("p4_pkt",     32'(pkt_cnt),  32'h3);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("p4_drain",   32'(out_valid), 32'h0);

        // XNOR and parity
        drive(1'b1, 8'hAA, 8'hAA, 1'b1, 1'b1);
        tick();
        chk("xnor_data", 32'(out_data), 32'hFF);
        chk("xnor_acc",  32'(out_acc),  32'hFF);
`ifdef XOR_ACCUM_PARITY_EN
        chk("xnor_par",  32'(out_par),  32'h0);
`endif
        drive(1'b1, 8'h01, 8'h00, 1'b0, 1'b1);
        tick();
        chk("xor1_data", 32'(out_data), 32'h01);
        chk("xor1_pkt",  32'(pkt_cnt),  32'h5);
`ifdef XOR_ACCUM_PARITY_EN
        chk("xor1_par",  32'(out_par),  32'h1);
`endif
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();

        // backpressure: three beats into a two-entry FIFO
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h00, 1'b0, 1'b0);
        tick();
        chk("bp_rdy_1", 32'(in_ready), 32'h1);
        drive(1'b1, 8'h22, 8'h00, 1'b0, 1'b0);
        tick();
        chk("bp_full",  32'(in_ready), 32'h0);
        chk("bp_head",  32'(out_data), 32'h11);
        drive(1'b1, 8'h44, 8'h00, 1'b0, 1'b1);
        tick();
        chk("bp_held_rdy",  32'(in_ready), 32'h0);
        chk("bp_head_hold", 32'(out_data), 32'h11);
        chk("bp_head_acc",  32'(out_acc),  32'h11);
        chk("bp_pkt_hold",  32'(pkt_cnt),  32'h5);
        out_ready = 1'b1;
        tick();
        chk("bp_pop1_rdy",  32'(in_ready), 32'h1);
        chk("bp_pop1_data", 32'(out_data), 32'h22);
        chk("bp_pop1_acc",  32'(out_acc),  32'h33);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("bp_c_data", 32'(out_data), 32'h44);
        chk("bp_c_acc",  32'(out_acc),  32'h77);
        chk("bp_c_last", 32'(out_last), 32'h1);
        chk("bp_c_pkt",  32'(pkt_cnt),  32'h6);
        tick();
        chk("bp_empty",  32'(out_valid), 32'h0);

        // continuous streaming, ten packets of ten beats
        acc_m = 8'h00;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, i[7:0], 8'h5A, i[0], (i % 10) == 9);
            r_m   = i[0] ? ~(i[7:0] ^ 8'h5A) : (i[7:0] ^ 8'h5A);
            acc_m = acc_m ^ r_m;
            tick();
            chk("stream_vld_rdy", {30'h0, out_valid, in_ready}, 32'h3);
            chk("stream_data",    32'(out_data), 32'(r_m));
            chk("stream_acc",     32'(out_acc),  32'(acc_m));
            if ((i % 10) == 9) acc_m = 8'h00;
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("stream_pkt", 32'(pkt_cnt), 32'd16);
        tick();
        chk("stream_empty", 32'(out_valid), 32'h0);

        // asynchronous reset mid-packet with two entries queued
        out_ready = 1'b0;
        drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h05, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("mid_full", 32'(in_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_pkt",   32'(pkt_cnt),   32'h0);
        chk("mid_rst_rdy",   32'(in_ready),  32'h1);
        chk("mid_rst_data",  32'(out_data),  32'h0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 8'h0C, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("post_rst_acc", 32'(out_acc), 32'h0C);
        chk("post_rst_pkt", 32'(pkt_cnt), 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
